// File: rtl/ttl_logic_pkg.sv
// Shared helpers for the clocked TTL-style logic blocks: width derivation only,
// no channel-specific constants live here.
package ttl_logic_pkg;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      r++;
    end
    return r;
  endfunction

  // Index width for n items, never narrower than one bit.
  function automatic int sel_width(input int n);
    return (clog2(n) < 1) ? 1 : clog2(n);
  endfunction

endpackage

// File: rtl/ttl_slot_counter.sv
// Round-robin sequencer: slot counter, channel counter, hold/clear handling
// and a one-cycle pulse when the channel counter wraps back to 0.
module ttl_slot_counter
  import ttl_logic_pkg::*;
#(
  parameter  int CHANNELS    = 2,
  parameter  int SLOT_CYCLES = 1,
  localparam int SELW        = sel_width(CHANNELS),
  localparam int SLOTW       = sel_width(SLOT_CYCLES)
) (
  input  logic            clk,
  input  logic            srst,
  input  logic            clear_i,
  input  logic            hold_i,
  output logic [SELW-1:0] cnt_o,
  output logic            wrap_o
);

  localparam logic [SLOTW-1:0] SLOT_LAST = SLOTW'(SLOT_CYCLES - 1);
  localparam logic [SELW-1:0]  CNT_LAST  = SELW'(CHANNELS - 1);

  logic [SLOTW-1:0] slot_q, slot_d;
  logic [SELW-1:0]  cnt_q, cnt_d;
  logic             wrap_q, wrap_d;

  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (clear_i) begin
      slot_d = '0;
      cnt_d  = '0;
    end else if (!hold_i) begin
      // Hold wins over slot expiry, so a held channel never advances or wraps.
      if (slot_q == SLOT_LAST) begin
        slot_d = '0;
        wrap_d = (cnt_q == CNT_LAST);
        cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      end else begin
        slot_d = slot_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      slot_q <= '0;
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign wrap_o = wrap_q;

endmodule

// File: rtl/ttl_mux_seq.sv
// Registered CHANNELS-to-1 word mux with external-select and auto round-robin
// modes; active-low gate forces the registered output to zero.
module ttl_mux_seq
  import ttl_logic_pkg::*;
#(
  parameter  int WIDTH       = 4,
  parameter  int CHANNELS    = 2,
  parameter  int SLOT_CYCLES = 1,
  localparam int SELW        = sel_width(CHANNELS)
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      nG,
  input  logic                      MODE,
  input  logic [SELW-1:0]           SEL,
  input  logic                      HOLD,
  input  logic [CHANNELS*WIDTH-1:0] D,
  output logic [WIDTH-1:0]          Y,
  output logic [SELW-1:0]           CH,
  output logic                      VALID,
  output logic                      WRAP
);

  localparam logic [SELW:0] CH_LIMIT = (SELW + 1)'(CHANNELS);

  logic [WIDTH-1:0] d_arr [CHANNELS];
  logic [WIDTH-1:0] y_q, y_d;
  logic [SELW-1:0]  ch_q, ch_d;
  logic             valid_q, valid_d;
  logic             mode_q;
  logic [SELW-1:0]  cnt;
  logic             seq_clear;
  logic             sel_ok;

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign d_arr[gi] = D[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // Counters only run once auto mode was already active at the previous edge;
  // external mode and the mode-entry edge both restart the sequence at 0.
  assign seq_clear = ~(MODE & mode_q);
  assign sel_ok    = ({1'b0, SEL} < CH_LIMIT);

  ttl_slot_counter #(
    .CHANNELS    (CHANNELS),
    .SLOT_CYCLES (SLOT_CYCLES)
  ) u_slot_counter (
    .clk     (CLK),
    .srst    (RST),
    .clear_i (seq_clear),
    .hold_i  (HOLD),
    .cnt_o   (cnt),
    .wrap_o  (WRAP)
  );

  always_comb begin
    y_d     = '0;
    ch_d    = SEL;
    valid_d = 1'b0;
    if (MODE) begin
      ch_d    = cnt;
      valid_d = ~nG;
      if (!nG) begin
        y_d = d_arr[cnt];
      end
    end else if (!nG && sel_ok) begin
      valid_d = 1'b1;
      y_d     = d_arr[SEL];
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      y_q     <= '0;
      ch_q    <= '0;
      valid_q <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      y_q     <= y_d;
      ch_q    <= ch_d;
      valid_q <= valid_d;
      mode_q  <= MODE;
    end
  end

  assign Y     = y_q;
  assign CH    = ch_q;
  assign VALID = valid_q;

endmodule

// File: tb/tb_ttl_mux_seq.sv
// Scoreboard bench for ttl_mux_seq (4x4-bit, 2-cycle slots) plus two small
// external-mode builds exercising out-of-range select.
module tb_ttl_mux_seq;

  localparam int NCH = 4;
  localparam int SC  = 2;

  typedef struct packed {
    logic [3:0] y;
    logic [1:0] ch;
    logic       valid;
    logic       wrap;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST, nG, MODE, HOLD;
  logic [1:0]  SEL;
  logic [15:0] D;
  logic [3:0]  Y;
  logic [1:0]  CH;
  logic        VALID, WRAP;

  logic        mode_ext = 1'b0;
  logic [2:0]  sel5;
  logic [19:0] d5;
  logic [3:0]  y5;
  logic [2:0]  ch5;
  logic        v5, w5;
  logic [1:0]  sel3;
  logic [11:0] d3;
  logic [3:0]  y3;
  logic [1:0]  ch3;
  logic        v3, w3;

  always #5 CLK = ~CLK;

  ttl_mux_seq #(.WIDTH(4), .CHANNELS(4), .SLOT_CYCLES(2)) dut (
    .CLK(CLK), .RST(RST), .nG(nG), .MODE(MODE), .SEL(SEL), .HOLD(HOLD),
    .D(D), .Y(Y), .CH(CH), .VALID(VALID), .WRAP(WRAP)
  );

  ttl_mux_seq #(.WIDTH(4), .CHANNELS(5), .SLOT_CYCLES(2)) dut5 (
    .CLK(CLK), .RST(RST), .nG(nG), .MODE(mode_ext), .SEL(sel5), .HOLD(HOLD),
    .D(d5), .Y(y5), .CH(ch5), .VALID(v5), .WRAP(w5)
  );

  ttl_mux_seq #(.WIDTH(4), .CHANNELS(3), .SLOT_CYCLES(2)) dut3 (
    .CLK(CLK), .RST(RST), .nG(nG), .MODE(mode_ext), .SEL(sel3), .HOLD(HOLD),
    .D(d3), .Y(y3), .CH(ch3), .VALID(v3), .WRAP(w3)
  );

  int   n_total = 0;
  int   n_pass  = 0;
  exp_t sb[$];
  int   m_cnt   = 0;
  int   m_slot  = 0;
  logic m_mode  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] dword(input int k);
    return D[k*4 +: 4];
  endfunction

  // Push the expected result for the current inputs, clock once, pop and compare.
  task automatic cycle(input string tag);
    exp_t e;
    exp_t g;
    e = '0;
    if (RST) begin
      m_cnt  = 0;
      m_slot = 0;
      m_mode = 1'b0;
    end else begin
      if (!MODE) begin
        e.ch    = SEL;
        e.valid = !nG;
        e.y     = nG ? 4'h0 : dword(int'(SEL));
        m_cnt   = 0;
        m_slot  = 0;
      end else begin
        e.ch    = 2'(m_cnt);
        e.valid = !nG;
        e.y     = nG ? 4'h0 : dword(m_cnt);
        if (!m_mode) begin
          m_cnt  = 0;
          m_slot = 0;
        end else if (!HOLD) begin
          if (m_slot == SC - 1) begin
            m_slot = 0;
            e.wrap = (m_cnt == NCH - 1);
            m_cnt  = (m_cnt + 1) % NCH;
          end else begin
            m_slot++;
          end
        end
      end
      m_mode = MODE;
    end
    sb.push_back(e);
    @(posedge CLK);
    #1;
    g = sb.pop_front();
    chk({tag, ".y"},     32'(Y),     32'(g.y));
    chk({tag, ".ch"},    32'(CH),    32'(g.ch));
    chk({tag, ".valid"}, 32'(VALID), 32'(g.valid));
    chk({tag, ".wrap"},  32'(WRAP),  32'(g.wrap));
  endtask

  logic [3:0] seq [8];
  int         wraps;
  logic       prev_wrap;
  int         guard;

  initial begin
    seq = '{4'hA, 4'hA, 4'hB, 4'hB, 4'hC, 4'hC, 4'hD, 4'hD};
    sel5 = 3'd0; d5 = 20'h54321;
    sel3 = 2'd0; d3 = 12'h987;

    // Reset with garbage on every input.
    RST = 1'b1; MODE = 1'b1; HOLD = 1'b1; nG = 1'($urandom);
    SEL = 2'($urandom); D = 16'($urandom);
    @(posedge CLK); #1;
    cycle("rst");
    cycle("rst");
    chk("rst_y", 32'(Y), 32'h0);
    chk("rst_wrap", 32'(WRAP), 32'h0);

    // Release straight into auto mode.
    RST = 1'b0; HOLD = 1'b0; nG = 1'b0; SEL = 2'd0; D = 16'hDCBA;
    cycle("entry");
    chk("entry_wrap", 32'(WRAP), 32'h0);
    wraps = 0;
    prev_wrap = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle("auto");
      if (i < 8) chk("seq_y", 32'(Y), 32'(seq[i]));
      if (prev_wrap) chk("wrap_then_a", 32'(Y), 32'hA);
      prev_wrap = WRAP;
      if (WRAP) wraps++;
    end
    chk("wrap_count", 32'(wraps), 32'd2);

    // Gate mid-sequence: outputs blanked, sequencer keeps running.
    cycle("pre_gate");
    nG = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("gate");
      chk("gate_valid", 32'(VALID), 32'h0);
    end
    nG = 1'b0;
    for (int i = 0; i < 4; i++) cycle("ungate");

    // Hold on channel 1 with live data change.
    guard = 0;
    while (!(m_cnt == 1 && m_slot == 1) && guard < 20) begin
      cycle("seek1");
      guard++;
    end
    chk("hold_sync_ch", 32'(CH), 32'd1);
    HOLD = 1'b1;
    cycle("hold");
    chk("hold_y_b", 32'(Y), 32'hB);
    D[7:4] = 4'h7;
    for (int i = 0; i < 4; i++) begin
      cycle("hold");
      chk("hold_ch", 32'(CH), 32'd1);
      chk("hold_y_7", 32'(Y), 32'h7);
    end
    HOLD = 1'b0;
    cycle("release");
    chk("release_ch1", 32'(CH), 32'd1);
    cycle("release");
    chk("release_ch2", 32'(CH), 32'd2);
    D[7:4] = 4'hB;

    // Mode 1->0->1 at cnt=2.
    guard = 0;
    while (m_cnt != 2 && guard < 20) begin
      cycle("seek2");
      guard++;
    end
    MODE = 1'b0; SEL = 2'd2;
    cycle("ext");
    chk("ext_y_c", 32'(Y), 32'hC);
    chk("ext_ch2", 32'(CH), 32'd2);
    MODE = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle("reentry");
      chk("reentry_y_a", 32'(Y), 32'hA);
      chk("reentry_wrap", 32'(WRAP), 32'h0);
    end

    // External select sweep, gated select, out-of-range builds.
    MODE = 1'b0;
    for (int s = 0; s < 4; s++) begin
      SEL = 2'(s);
      cycle("ext_sel");
    end
    nG = 1'b1; SEL = 2'd1;
    cycle("ext_gate");
    nG = 1'b0; sel5 = 3'd5; sel3 = 2'd3;
    cycle("ext_oor");
    chk("oor5_y", 32'(y5), 32'h0);
    chk("oor5_valid", 32'(v5), 32'h0);
    chk("oor3_y", 32'(y3), 32'h0);
    chk("oor3_valid", 32'(v3), 32'h0);
    sel5 = 3'd4; sel3 = 2'd2;
    cycle("ext_inr");
    chk("inr5_y", 32'(y5), 32'h5);
    chk("inr5_valid", 32'(v5), 32'h1);
    chk("inr3_y", 32'(y3), 32'h9);
    chk("inr3_ch", 32'(ch3), 32'd2);

    // Reset landing on the slot expiry that would otherwise wrap.
    MODE = 1'b1;
    guard = 0;
    while (!(m_mode && m_cnt == 3 && m_slot == 1) && guard < 20) begin
      cycle("seek3");
      guard++;
    end
    chk("seek3_ch", 32'(CH), 32'd3);
    RST = 1'b1;
    cycle("rst_mid");
    chk("rst_mid_wrap", 32'(WRAP), 32'h0);
    chk("rst_mid_y", 32'(Y), 32'h0);
    RST = 1'b0;
    cycle("post_rst");
    cycle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
